row_t2b: RTL and testbench
==========================

ROW_T2B -- requirements
Module: row_t2b

Interface
REQ-001 Parameter TW, default 16, thermometer width; fixed at 16 for this row, no other value supported.
REQ-002 Parameter BW, default 4, binary width; equals log2(TW).
REQ-003 Parameter CNT_W, default 8, width of the error event counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  data_i/oc_i valid this cycle.
REQ-007 in_ready  output  1  block accepts data_i/oc_i this cycle.
REQ-008 data_i  input  TW  thermometer row code, LSB-filled.
REQ-009 oc_i  input  1  offset/complement mode of the row: 0 plain, 1 complemented and shifted.
REQ-010 out_valid  output  1  data_o/err_o valid.
REQ-011 out_ready  input  1  downstream accepts data_o.
REQ-012 data_o  output  BW  recovered binary row value.
REQ-013 err_o  output  1  word needed bubble correction or was out of range for its mode.
REQ-014 clr_cnt  input  1  synchronous clear of err_cnt_o.
REQ-015 err_cnt_o  output  CNT_W  saturating count of words delivered with err_o=1.

Function
REQ-016 Transfer occurs on a cycle with valid and ready both high, at input and at output independently.
REQ-017 Two-stage pipeline: S1 holds bubble-corrected code, oc and the correction flag; S2 holds data_o and err_o.
REQ-018 With out_ready held high, data_o appears exactly 2 cycles after input acceptance; one word per cycle sustained.
REQ-019 S2 advances when out_ready=1 or S2 empty; S1 advances when S1 empty or S2 advances; in_ready = !S1_valid or S2 advances.
REQ-020 While out_valid=1 and out_ready=0, data_o, err_o and out_valid hold stable; no word dropped or duplicated.
REQ-021 Bubble correction: c[k] = majority(t[k-1], t[k], t[k+1]), with t[-1]=t[0] and t[TW]=t[TW-1].
REQ-022 Count n = number of ones in c, range 0..16 (5 bits internally).
REQ-023 oc=0: data_o = n, except n=16, where data_o = 15.
REQ-024 oc=1: data_o = (16 - n) mod 16, so n=16 gives 0 and n=0 gives 0.
REQ-025 Decode is the exact inverse of the row binary-to-thermometer encoder for all 32 legal (value, oc) codes, with err_o=0.
REQ-026 err_o=1 when any of these holds: c != data_i; c is not monotonic (a 0 below a 1); oc=0 with n=16; oc=1 with n=0.
REQ-027 err_cnt_o increments by 1 on each output transfer with err_o=1 and saturates at 2^CNT_W-1.
REQ-028 clr_cnt=1 forces err_cnt_o to 0 next cycle and takes priority over a simultaneous increment.
REQ-029 data_i and oc_i are ignored when in_valid=0 or in_ready=0.

Reset
REQ-030 rst_n=0 at a clock edge forces S1_valid=0, S2_valid=0, out_valid=0, data_o=0, err_o=0 and err_cnt_o=0.
REQ-031 Reset mid-stream discards every in-flight word; nothing is emitted for those words after reset releases.
REQ-032 in_ready=1 in the first cycle after rst_n returns high.

Structure
REQ-033 Shared package flb_pkg holds TW, BW, CNT_W defaults and the row binary type; the encoder side uses the same package.
REQ-034 One sub-module, T2B: purely combinational bubble correction, popcount, monotonic check and error flag; row_t2b adds the mode mapping, pipeline, handshake and counter.

Verification
REQ-035 data_i=16'h00FF, oc=0, out_ready=1 -> data_o=8, err_o=0, 2 cycles after acceptance.
REQ-036 data_i=16'h00FF, oc=1 -> data_o=8; data_i=16'hFFFF, oc=1 -> data_o=0, err_o=0; data_i=16'h0000, oc=1 -> data_o=0, err_o=1.
REQ-037 data_i=16'h00F7, oc=0 (single bubble) -> data_o=8, err_o=1, err_cnt_o increments by 1.
REQ-038 Stream of 5 words, out_ready=0 for 3 cycles mid-stream -> in_ready drops after S1 and S2 fill, all 5 words emerge in order, none lost.
REQ-039 Exhaustive loop over value 0..15 and oc 0/1 through the encoder model -> data_o = value and err_o=0 for every case.
REQ-040 rst_n=0 with 2 words in flight -> out_valid=0 next cycle, err_cnt_o=0, no stale output after release.

Source files
------------

// File: rtl/flb_pkg.sv
// flb_pkg: shared row widths, binary row type and offset/complement mode for the row encoder and decoder.
package flb_pkg;
    localparam int ROW_TW    = 16;
    localparam int ROW_BW    = 4;
    localparam int ROW_CNT_W = 8;
    typedef logic [ROW_BW-1:0] row_bin_t;
    typedef enum logic {OC_PLAIN = 1'b0, OC_COMP = 1'b1} oc_mode_t;
endpackage

// File: rtl/row_t2b_t2b.sv
// row_t2b_t2b: combinational bubble correction on the raw code, and popcount/monotonic/error on the stage-1 code.
module row_t2b_t2b
    import flb_pkg::*;
#(
    parameter int TW = ROW_TW,
    parameter int NW = $clog2(ROW_TW + 1)
) (
    input  logic [TW-1:0] code,
    output logic [TW-1:0] corr,
    output logic          bubble,
    input  logic [TW-1:0] s1_code,
    input  logic          s1_oc,
    input  logic          s1_bubble,
    output logic [NW-1:0] n,
    output logic          err
);
    logic [TW+1:0] ext;
    logic          non_mono;

    // Edge bits are replicated so the end positions vote with themselves.
    assign ext = {code[TW-1], code, code[0]};

    always_comb begin
        corr = '0;
        for (int k = 0; k < TW; k++)
            corr[k] = (ext[k] & ext[k+1]) | (ext[k] & ext[k+2]) | (ext[k+1] & ext[k+2]);
    end

    assign bubble = corr != code;

    always_comb begin
        n = '0;
        for (int k = 0; k < TW; k++)
            n = n + NW'(s1_code[k]);
    end

    assign non_mono = |((s1_code >> 1) & ~s1_code);
    assign err      = s1_bubble | non_mono | (s1_oc ? n == '0 : n == NW'(TW));
endmodule

// File: rtl/row_t2b.sv
// row_t2b: two-stage valid/ready thermometer-to-binary row decoder with saturating error counter.
module row_t2b
    import flb_pkg::*;
#(
    parameter int TW    = ROW_TW,
    parameter int BW    = ROW_BW,
    parameter int CNT_W = ROW_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TW-1:0]    data_i,
    input  logic             oc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BW-1:0]    data_o,
    output logic             err_o,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int NW = BW + 1;

    logic [TW-1:0] corr, s1_code;
    logic          bubble, s1_bubble, s1_valid, err, s1_adv, s2_adv;
    oc_mode_t      s1_oc;
    logic [NW-1:0] n;
    row_bin_t      val;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    row_t2b_t2b #(.TW(TW), .NW(NW)) u_t2b (
        .code      (data_i),
        .corr      (corr),
        .bubble    (bubble),
        .s1_code   (s1_code),
        .s1_oc     (s1_oc == OC_COMP),
        .s1_bubble (s1_bubble),
        .n         (n),
        .err       (err)
    );

    // A full row (n == TW) only reaches the top bit of n; plain mode clamps it, complement mode wraps it to 0.
    assign val = s1_oc == OC_COMP ? (~n[BW-1:0]) + row_bin_t'(1) : (n[BW] ? '1 : n[BW-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_code   <= '0;
            s1_oc     <= OC_PLAIN;
            s1_bubble <= 1'b0;
            out_valid <= 1'b0;
            data_o    <= '0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_code   <= corr;
                    s1_oc     <= oc_mode_t'(oc_i);
                    s1_bubble <= bubble;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    data_o <= val;
                    err_o  <= err;
                end
            end
            if (clr_cnt)
                err_cnt_o <= '0;
            else if (out_valid && out_ready && err_o && err_cnt_o != '1)
                err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_row_t2b.sv
// tb_row_t2b: randomized scoreboard bench for row_t2b against a behavioural decode model.
module tb_row_t2b;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, oc_i = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
    logic [15:0] data_i = '0;
    logic        in_ready, out_valid, err_o;
    logic [3:0]  data_o;
    logic [7:0]  err_cnt_o;

    typedef struct {
        logic [3:0] d;
        logic       e;
        bit         lat;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   vec = 0, fails = 0, cyc = 0;

    row_t2b dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_i    (data_i),
        .oc_i      (oc_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_o    (data_o),
        .err_o     (err_o),
        .clr_cnt   (clr_cnt),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] enc(input int v, input bit oc);
        int n;
        n = oc ? (v == 0 ? 16 : 16 - v) : v;
        return 16'((33'd1 << n) - 1);
    endfunction

    // Majority vote, count, then decide: a valid code is exactly n low ones and matches the input.
    task automatic model(input logic [15:0] t, input bit oc, output logic [3:0] v, output logic e);
        logic [17:0] x;
        logic [15:0] c;
        int          n, a, b, m;
        x = {t[15], t, t[0]};
        n = 0;
        for (int k = 0; k < 16; k++) begin
            a = x[k]; b = x[k+1]; m = x[k+2];
            c[k] = (a + b + m) >= 2;
            n += c[k];
        end
        v = oc ? 4'((16 - n) % 16) : (n == 16 ? 4'd15 : 4'(n));
        e = (c != t) || (c != 16'((33'd1 << n) - 1)) || (!oc && n == 16) || (oc && n == 0);
    endtask

    task automatic idle(input logic orr, input logic clr);
        @(negedge clk);
        in_valid  = 1'b0;
        data_i    = 16'($urandom);
        oc_i      = 1'($urandom);
        out_ready = orr;
        clr_cnt   = clr;
    endtask

    task automatic send(input logic [15:0] t, input bit oc, input logic [3:0] d, input logic e,
                        input bit lat, input bit rnd);
        bit done = 0;
        for (int r = 0; r < 200 && !done; r++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            data_i    = t;
            oc_i      = oc;
            out_ready = rnd ? ($urandom % 3 != 0) : 1'b1;
            clr_cnt   = rnd ? ($urandom % 50 == 0) : 1'b0;
            #1;
            if (in_ready) begin
                q.push_back('{d: d, e: e, lat: lat, acc: cyc});
                done = 1;
            end
        end
        if (!done) begin
            fails++;
            $display("FAIL accept_timeout: in_ready stuck low for word %h", t);
        end
    endtask

    task automatic send_m(input logic [15:0] t, input bit oc, input bit lat, input bit rnd);
        logic [3:0] d;
        logic       e;
        model(t, oc, d, e);
        send(t, oc, d, e, lat, rnd);
    endtask

    // Monitor: pops on every output transfer, checks hold-while-stalled and tracks the error counter.
    initial begin
        bit         stall = 0;
        logic [3:0] hd = '0;
        logic       he = 1'b0;
        int         cnt_m = 0;
        exp_t       x;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                q.delete();
                cnt_m = 0;
                stall = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", {data_o, err_o}, {hd, he});
                end
                chk("err_cnt", err_cnt_o, cnt_m);
                x = '{d: '0, e: 1'b0, lat: 0, acc: 0};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output: data_o=%0d err_o=%0b with nothing outstanding", data_o, err_o);
                    end else begin
                        x = q.pop_front();
                        chk("data_o", data_o, x.d);
                        chk("err_o", err_o, x.e);
                        if (x.lat) chk("latency", cyc - x.acc, 2);
                    end
                end
                cnt_m = clr_cnt ? 0 : (out_valid && out_ready && x.e && cnt_m != 255) ? cnt_m + 1 : cnt_m;
                stall = out_valid && !out_ready;
                hd = data_o;
                he = err_o;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i, k, v;
        bit  saw;
        logic [15:0] t;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_err", {data_o, err_o}, 5'd0);
        chk("rst_err_cnt", err_cnt_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        send(16'h00FF, 0, 4'd8, 1'b0, 1, 0);
        send(16'h00FF, 1, 4'd8, 1'b0, 1, 0);
        send(16'hFFFF, 1, 4'd0, 1'b0, 1, 0);
        send(16'h0000, 1, 4'd0, 1'b1, 1, 0);
        send(16'h00F7, 0, 4'd8, 1'b1, 1, 0);
        send(16'hFFFF, 0, 4'd15, 1'b1, 1, 0);
        repeat (4) idle(1, 0);

        i = 0; k = 0; saw = 0;
        while (i < 5 && k < 40) begin
            @(negedge clk);
            out_ready = !(k >= 2 && k <= 4);
            in_valid  = 1'b1;
            oc_i      = 1'b0;
            data_i    = enc(i + 3, 0);
            #1;
            if (!in_ready) saw = 1;
            else begin
                q.push_back('{d: 4'(i + 3), e: 1'b0, lat: 0, acc: cyc});
                i++;
            end
            k++;
        end
        chk("stream_backpressure", saw, 1);
        chk("stream_accepted", i, 5);
        repeat (4) idle(1, 0);

        for (int oc = 0; oc < 2; oc++)
            for (v = 0; v < 16; v++)
                send(enc(v, oc[0]), oc[0], 4'(v), 1'b0, 1, 0);
        repeat (4) idle(1, 0);

        for (int r = 0; r < 1500; r++) begin
            if ($urandom % 4 == 0) idle($urandom % 2 == 0, $urandom % 50 == 0);
            else begin
                v = $urandom % 16;
                t = enc(v, 1'($urandom));
                case ($urandom % 3)
                    0: ;
                    1: t[$urandom % 16] ^= 1'b1;
                    default: t = 16'($urandom);
                endcase
                send_m(t, 1'($urandom), 0, 1);
            end
        end
        repeat (4) idle(1, 0);

        for (int r = 0; r < 300; r++) send(16'h00F7, 0, 4'd8, 1'b1, 1, 0);
        repeat (4) idle(1, 0);
        #1;
        chk("err_cnt_saturated", err_cnt_o, 255);

        send(16'h00F7, 0, 4'd8, 1'b1, 1, 0);
        idle(1, 0);
        idle(1, 1);
        idle(1, 0);
        #1;
        chk("clr_priority", err_cnt_o, 0);

        send(16'h0000, 1, 4'd0, 1'b1, 0, 0);
        repeat (3) idle(1, 0);
        send(16'h003F, 0, 4'd6, 1'b0, 0, 0);
        send(16'h0FFF, 1, 4'd4, 1'b0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_err_cnt", err_cnt_o, 0);
        repeat (5) idle(1, 0);

        for (int r = 0; r < 50 && (q.size() != 0 || out_valid); r++) idle(1, 0);
        chk("drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end
endmodule
